pipe_hazard_ctrl: RTL and testbench

Hazard and sequencing controller for the 5-stage RISC-V pipeline (F/D/E/M/W).
- Drives stall and flush enables for the fetch/decode/execute/memory pipeline registers, and the E-stage 3:1 forwarding mux selects.
- Stretches the M stage while a multi-cycle data memory is not ready, with a timeout and error flag.
- Maintains saturating stall and flush performance counters.

---
 rtl/pipe_hazard_ctrl.sv | 176 +++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for a 5-stage RISC-V pipeline: forwarding selects,
// load-use / branch / memory-wait stall and flush control, and saturating perf counters.
module pipe_hazard_ctrl #(
    parameter int MEM_TIMEOUT = 15,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       Rs1D,
    input  logic [4:0]       Rs2D,
    input  logic [4:0]       Rs1E,
    input  logic [4:0]       Rs2E,
    input  logic [4:0]       RdE,
    input  logic [4:0]       RdM,
    input  logic [4:0]       RdW,
    input  logic             RegWriteM,
    input  logic             RegWriteW,
    input  logic             LoadE,
    input  logic             PCSrcE,
    input  logic             MemReqM,
    input  logic             MemReadyM,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             StallM,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushW,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             MemErr,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt
);

    typedef enum logic [1:0] {
        RUN   = 2'd0,
        MWAIT = 2'd1,
        TOUT  = 2'd2
    } mem_state_t;

    localparam logic [7:0]       WAIT_LIMIT = 8'(MEM_TIMEOUT);
    localparam logic [CNT_W-1:0] CNT_MAX    = '1;

    mem_state_t       state_q;
    logic [7:0]       wait_q;
    logic             mem_err_q;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
    logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

    logic             lw_stall;
    logic             mem_stall;
    logic             timeout;
    logic             stall_f, stall_d, stall_e, stall_m;
    logic             flush_d, flush_e, flush_w;

    // Forwarding selects for both E operands; M result has priority over W.
    logic [4:0] rs_e    [2];
    logic [1:0] fwd_sel [2];

    assign rs_e[0] = Rs1E;
    assign rs_e[1] = Rs2E;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            assign fwd_sel[gi] =
                (RegWriteM && (RdM != 5'd0) && (RdM == rs_e[gi])) ? 2'b10 :
                (RegWriteW && (RdW != 5'd0) && (RdW == rs_e[gi])) ? 2'b01 :
                                                                    2'b00;
        end
    endgenerate

    assign lw_stall  = LoadE && (RdE != 5'd0) && ((RdE == Rs1D) || (RdE == Rs2D));
    assign timeout   = (state_q == TOUT);
    assign mem_stall = MemReqM && !MemReadyM && !timeout;

    // A memory stall freezes D and E, so any branch or load-use hazard waits for release.
    always_comb begin
        stall_f = 1'b0;
        stall_d = 1'b0;
        stall_e = 1'b0;
        stall_m = 1'b0;
        flush_d = 1'b0;
        flush_e = 1'b0;
        flush_w = 1'b0;
        if (mem_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (PCSrcE) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (lw_stall) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            flush_e = 1'b1;
        end
    end

    assign StallF    = rst & stall_f;
    assign StallD    = rst & stall_d;
    assign StallE    = rst & stall_e;
    assign StallM    = rst & stall_m;
    assign FlushD    = rst & flush_d;
    assign FlushE    = rst & flush_e;
    assign FlushW    = rst & flush_w;
    assign ForwardAE = rst ? fwd_sel[0] : 2'b00;
    assign ForwardBE = rst ? fwd_sel[1] : 2'b00;
    assign MemErr    = rst & mem_err_q;
    assign StallCnt  = stall_cnt_q;
    assign FlushCnt  = flush_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= RUN;
            wait_q    <= 8'd0;
            mem_err_q <= 1'b0;
        end else begin
            case (state_q)
                RUN: begin
                    mem_err_q <= 1'b0;
                    if (MemReqM && !MemReadyM) begin
                        state_q <= MWAIT;
                        wait_q  <= 8'd1;
                    end
                end
                MWAIT: begin
                    if (MemReadyM || !MemReqM) begin
                        state_q   <= RUN;
                        wait_q    <= 8'd0;
                        mem_err_q <= 1'b0;
                    end else if (wait_q == WAIT_LIMIT) begin
                        state_q   <= TOUT;
                        mem_err_q <= 1'b1;
                    end else begin
                        wait_q <= wait_q + 8'd1;
                    end
                end
                TOUT: begin
                    state_q   <= RUN;
                    wait_q    <= 8'd0;
                    mem_err_q <= 1'b0;
                end
                default: begin
                    state_q   <= RUN;
                    wait_q    <= 8'd0;
                    mem_err_q <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (StallF && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + 1'b1;
        end
        if (FlushD && (flush_cnt_q != CNT_MAX)) begin
            flush_cnt_d = flush_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: forwarding, load-use, branch, memory wait,
// timeout, asynchronous reset and counter saturation.
module tb_pipe_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] Rs1D, Rs2D, Rs1E, Rs2E, RdE, RdM, RdW;
    logic       RegWriteM, RegWriteW, LoadE, PCSrcE, MemReqM, MemReadyM;
    logic       StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW;
    logic [1:0] ForwardAE, ForwardBE;
    logic       MemErr;
    logic [3:0] StallCnt, FlushCnt;

    logic [6:0] ctl;
    assign ctl = {StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW};

    localparam logic [6:0] CTL_NONE = 7'b0000000;
    localparam logic [6:0] CTL_MEM  = 7'b1111001;
    localparam logic [6:0] CTL_BR   = 7'b0000110;
    localparam logic [6:0] CTL_LW   = 7'b1100010;

    int n_assert = 0;
    int n_fail   = 0;

    pipe_hazard_ctrl #(
        .MEM_TIMEOUT (4),
        .CNT_W       (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .Rs1D      (Rs1D),
        .Rs2D      (Rs2D),
        .Rs1E      (Rs1E),
        .Rs2E      (Rs2E),
        .RdE       (RdE),
        .RdM       (RdM),
        .RdW       (RdW),
        .RegWriteM (RegWriteM),
        .RegWriteW (RegWriteW),
        .LoadE     (LoadE),
        .PCSrcE    (PCSrcE),
        .MemReqM   (MemReqM),
        .MemReadyM (MemReadyM),
        .StallF    (StallF),
        .StallD    (StallD),
        .StallE    (StallE),
        .StallM    (StallM),
        .FlushD    (FlushD),
        .FlushE    (FlushE),
        .FlushW    (FlushW),
        .ForwardAE (ForwardAE),
        .ForwardBE (ForwardBE),
        .MemErr    (MemErr),
        .StallCnt  (StallCnt),
        .FlushCnt  (FlushCnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        Rs1D = 5'd0; Rs2D = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        RdE = 5'd0; RdM = 5'd0; RdW = 5'd0;
        RegWriteM = 1'b0; RegWriteW = 1'b0; LoadE = 1'b0;
        PCSrcE = 1'b0; MemReqM = 1'b0; MemReadyM = 1'b0;
    endtask

    initial begin
        // Reset held with active hazards on the inputs: everything stays 0.
        rst = 1'b0;
        clear_inputs();
        RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5;
        MemReqM = 1'b1; LoadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
        #2;
        chk("rst_ctl", ctl, CTL_NONE);
        chk("rst_fwdA", ForwardAE, 2'b00);
        tick();
        tick();
        chk("rst_ctl_held", ctl, CTL_NONE);
        chk("rst_stallcnt", StallCnt, 4'd0);
        chk("rst_flushcnt", FlushCnt, 4'd0);
        chk("rst_memerr", MemErr, 1'b0);
        clear_inputs();
        rst = 1'b1;
        tick();

        // Forwarding
        RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5;
        RegWriteW = 1'b1; RdW = 5'd6; Rs2E = 5'd6;
        #1;
        chk("fwd_A_mem", ForwardAE, 2'b10);
        chk("fwd_B_wb", ForwardBE, 2'b01);
        chk("fwd_ctl", ctl, CTL_NONE);
        RdW = 5'd5; Rs2E = 5'd5;
        #1;
        chk("fwd_B_prio", ForwardBE, 2'b10);
        RegWriteM = 1'b0;
        #1;
        chk("fwd_A_wb_only", ForwardAE, 2'b01);
        RegWriteM = 1'b1; RdM = 5'd0; RdW = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        #1;
        chk("fwd_A_x0", ForwardAE, 2'b00);
        chk("fwd_B_x0", ForwardBE, 2'b00);
        clear_inputs();
        tick();

        // Load-use
        LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
        #1;
        chk("lw_ctl", ctl, CTL_LW);
        tick();
        chk("lw_stallcnt", StallCnt, 4'd1);
        LoadE = 1'b0;
        #1;
        chk("lw_gone", ctl, CTL_NONE);
        LoadE = 1'b1; RdE = 5'd0; Rs1D = 5'd0; Rs2D = 5'd0;
        #1;
        chk("lw_x0", ctl, CTL_NONE);
        tick();
        chk("lw_x0_cnt", StallCnt, 4'd1);

        // Branch together with load-use: branch wins
        PCSrcE = 1'b1; LoadE = 1'b1; RdE = 5'd7; Rs2D = 5'd7;
        #1;
        chk("br_ctl", ctl, CTL_BR);
        tick();
        chk("br_flushcnt", FlushCnt, 4'd1);
        chk("br_stallcnt", StallCnt, 4'd1);
        clear_inputs();
        tick();

        // Memory wait, 3 not-ready cycles, branch pending during the wait
        MemReqM = 1'b1; MemReadyM = 1'b0;
        #1;
        chk("mw_stall0", ctl, CTL_MEM);
        tick();
        PCSrcE = 1'b1;
        #1;
        chk("mw_stall1_br", ctl, CTL_MEM);
        tick();
        chk("mw_stall2_br", ctl, CTL_MEM);
        tick();
        MemReadyM = 1'b1;
        #1;
        chk("mw_release_br", ctl, CTL_BR);
        chk("mw_stallcnt", StallCnt, 4'd4);
        chk("mw_flushcnt_hold", FlushCnt, 4'd1);
        tick();
        chk("mw_flushcnt", FlushCnt, 4'd2);
        clear_inputs();
        #1;
        chk("mw_idle", ctl, CTL_NONE);

        // Timeout with MEM_TIMEOUT=4: 5 stalled cycles, one unstalled error cycle
        MemReqM = 1'b1; MemReadyM = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("to_stall%0d", i), {ctl, MemErr}, {CTL_MEM, 1'b0});
            tick();
        end
        chk("to_err_cycle", {ctl, MemErr}, {CTL_NONE, 1'b1});
        chk("to_cnt_err", StallCnt, 4'd9);
        tick();
        chk("to_resume", {ctl, MemErr}, {CTL_MEM, 1'b0});
        tick();
        chk("to_resume_cnt", StallCnt, 4'd10);

        // Asynchronous reset in the middle of a wait
        RegWriteM = 1'b1; RdM = 5'd5; Rs1E = 5'd5;
        rst = 1'b0;
        #1;
        chk("arst_ctl", {ctl, MemErr}, {CTL_NONE, 1'b0});
        chk("arst_fwdA", ForwardAE, 2'b00);
        chk("arst_stallcnt", StallCnt, 4'd0);
        tick();
        tick();
        chk("arst_no_err", MemErr, 1'b0);
        clear_inputs();
        MemReqM = 1'b1; MemReadyM = 1'b0;
        rst = 1'b1;
        // A fresh wait from RUN must take the full 5 stalls before timing out
        for (int i = 0; i < 5; i++) begin
            #1;
            chk($sformatf("arst_run%0d", i), {ctl, MemErr}, {CTL_MEM, 1'b0});
            tick();
        end
        chk("arst_to", {ctl, MemErr}, {CTL_NONE, 1'b1});
        chk("arst_to_cnt", StallCnt, 4'd5);
        clear_inputs();
        tick();

        // Saturation of the 4-bit stall counter
        LoadE = 1'b1; RdE = 5'd7; Rs1D = 5'd7;
        for (int i = 0; i < 9; i++) tick();
        chk("sat_mid", StallCnt, 4'd14);
        for (int i = 0; i < 11; i++) tick();
        chk("sat_top", StallCnt, 4'd15);
        chk("sat_flushcnt", FlushCnt, 4'd0);
        clear_inputs();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
